// File: rtl/regfile_mp.sv
// Multi-port register file with a per-entry pending scoreboard; entry 0 reads as zero.
// Optional same-cycle write-to-read forwarding when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NRD*ADDR_W-1:0]  i_rs_addr,
  output logic [NRD*DATA_W-1:0]  o_rs_data,
  output logic [NRD-1:0]         o_rs_busy,
  input  logic [NWR-1:0]         i_wr_en,
  input  logic [NWR*ADDR_W-1:0]  i_wr_addr,
  input  logic [NWR*DATA_W-1:0]  i_wr_data,
  input  logic                   i_alloc_en,
  input  logic [ADDR_W-1:0]      i_alloc_addr,
  output logic                   o_any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_d;
  logic [ADDR_W-1:0] w_rd_addr [NRD];
`ifdef REGFILE_MP_BYPASS_EN
  logic              w_rd_hit [NRD];
`endif

  // Writes release, then alloc re-marks, so alloc wins over a same-cycle write.
  always_comb begin
    w_pend_d = r_pend;
    for (int j = 0; j < int'(NWR); j++) begin
      if (i_wr_en[j]) w_pend_d[i_wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (i_alloc_en) w_pend_d[i_alloc_addr] = 1'b1;
    w_pend_d[0] = 1'b0;
  end

  // Ascending port loop: the last non-blocking assignment (highest index) wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          r_mem[i_wr_addr[j*ADDR_W +: ADDR_W]] <= i_wr_data[j*DATA_W +: DATA_W];
        end
      end
      r_pend <= w_pend_d;
    end
  end

  always_comb begin
    o_rs_data = '0;
    o_rs_busy = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      w_rd_addr[k] = i_rs_addr[k*ADDR_W +: ADDR_W];
      o_rs_data[k*DATA_W +: DATA_W] = r_mem[w_rd_addr[k]];
      o_rs_busy[k] = r_pend[w_rd_addr[k]];
`ifdef REGFILE_MP_BYPASS_EN
      w_rd_hit[k] = 1'b0;
      for (int j = 0; j < int'(NWR); j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == w_rd_addr[k])) begin
          w_rd_hit[k] = 1'b1;
          o_rs_data[k*DATA_W +: DATA_W] = i_wr_data[j*DATA_W +: DATA_W];
        end
      end
      if (w_rd_hit[k]) o_rs_busy[k] = i_alloc_en && (i_alloc_addr == w_rd_addr[k]);
`endif
      if (w_rd_addr[k] == '0) begin
        o_rs_data[k*DATA_W +: DATA_W] = '0;
        o_rs_busy[k] = 1'b0;
      end
    end
  end

  assign o_any_busy = |r_pend;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; expected read results queued at drive time, checked at sample.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rs_data;
  logic [NR-1:0]    rs_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             any_busy;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rs_addr   (rs_addr),
    .o_rs_data   (rs_data),
    .o_rs_busy   (rs_busy),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_alloc_en  (alloc_en),
    .i_alloc_addr(alloc_addr),
    .o_any_busy  (any_busy)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and return all stimulus to idle.
  task automatic cyc();
    @(negedge clk);
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    rs_addr  = '0;
  endtask

  task automatic wr(input int j, input int a, input logic [31:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = AW'(a);
  endtask

  task automatic expect_rd(input string tag, input int p, input int a,
                           input logic [31:0] d, input logic b);
    exp_t e;
    rs_addr[p*AW +: AW] = AW'(a);
    e.tag = tag; e.port = p; e.data = d; e.busy = b;
    q.push_back(e);
  endtask

  task automatic check_rd();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      assert (rs_data[e.port*DW +: DW] === e.data) else begin
        n_fail++;
        $error("FAIL %s data p%0d: observed %h expected %h", e.tag, e.port,
               rs_data[e.port*DW +: DW], e.data);
      end
      n_tests++;
      assert (rs_busy[e.port] === e.busy) else begin
        n_fail++;
        $error("FAIL %s busy p%0d: observed %b expected %b", e.tag, e.port,
               rs_busy[e.port], e.busy);
      end
    end
  endtask

  task automatic check_any(input string tag, input logic b);
    n_tests++;
    assert (any_busy === b) else begin
      n_fail++;
      $error("FAIL %s any_busy: observed %b expected %b", tag, any_busy, b);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;

    // 1: write x5, confirm, then reset for 2 cycles with a write and alloc asserted.
    cyc(); wr(0, 5, 32'hDEADBEEF);
    cyc(); expect_rd("t1_pre", 0, 5, 32'hDEADBEEF, 1'b0); check_rd();
    rst_n = 1'b0; wr(1, 6, 32'h66666666); alloc(6);
    cyc(); rst_n = 1'b0; alloc(5);
    cyc(); rst_n = 1'b1;
    expect_rd("t1_x5", 0, 5, 32'h0, 1'b0);
    expect_rd("t1_x6", 1, 6, 32'h0, 1'b0);
    check_rd(); check_any("t1", 1'b0);

    // 2: writes to x0 are dropped; alloc x0 ignored.
    cyc(); wr(0, 0, 32'hFFFFFFFF); wr(1, 8, 32'h88888888); alloc(0);
    cyc();
    expect_rd("t2_x0p0", 0, 0, 32'h0, 1'b0);
    expect_rd("t2_x0p1", 1, 0, 32'h0, 1'b0);
    check_rd(); check_any("t2", 1'b0);
    cyc(); expect_rd("t2_x8", 0, 8, 32'h88888888, 1'b0); check_rd();

    // 3: same-address writes, port 1 wins.
    cyc(); wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222);
    cyc();
    expect_rd("t3_p0", 0, 7, 32'h22222222, 1'b0);
    expect_rd("t3_p1", 1, 7, 32'h22222222, 1'b0);
    check_rd();

    // 4: alloc x3, held pending, then write releases it.
    cyc(); alloc(3);
    cyc(); expect_rd("t4_n1", 0, 3, 32'h0, 1'b1); check_rd(); check_any("t4_n1", 1'b1);
    cyc(); expect_rd("t4_hold", 1, 3, 32'h0, 1'b1); check_rd();
    cyc(); wr(0, 3, 32'h000000A5);
`ifdef REGFILE_MP_BYPASS_EN
    expect_rd("t4_m", 0, 3, 32'h000000A5, 1'b0);
`else
    expect_rd("t4_m", 0, 3, 32'h0, 1'b1);
`endif
    check_rd();
    cyc(); expect_rd("t4_m1", 0, 3, 32'h000000A5, 1'b0); check_rd(); check_any("t4_m1", 1'b0);

    // 5: alloc wins over same-cycle write; re-alloc holds; write via port 1 releases.
    cyc(); alloc(9); wr(1, 9, 32'h00000055);
`ifdef REGFILE_MP_BYPASS_EN
    expect_rd("t5_same", 1, 9, 32'h00000055, 1'b1);
`else
    expect_rd("t5_same", 1, 9, 32'h0, 1'b0);
`endif
    check_rd();
    cyc(); expect_rd("t5_next", 0, 9, 32'h00000055, 1'b1); check_rd(); check_any("t5", 1'b1);
    alloc(9);
    cyc(); expect_rd("t5_realloc", 0, 9, 32'h00000055, 1'b1); check_rd();
    wr(1, 9, 32'h00000099);
    cyc(); expect_rd("t5_rel", 1, 9, 32'h00000099, 1'b0); check_rd(); check_any("t5_rel", 1'b0);

    // 6: read-during-write on x4.
    cyc(); wr(0, 4, 32'h00001234);
`ifdef REGFILE_MP_BYPASS_EN
    expect_rd("t6_same", 0, 4, 32'h00001234, 1'b0);
`else
    expect_rd("t6_same", 0, 4, 32'h0, 1'b0);
`endif
    expect_rd("t6_other", 1, 7, 32'h22222222, 1'b0);
    check_rd();
    cyc(); expect_rd("t6_next", 1, 4, 32'h00001234, 1'b0); check_rd();

    // Mid-operation reset drops pending state.
    cyc(); alloc(12);
    cyc(); check_any("rst_pre", 1'b1); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    expect_rd("rst_x12", 0, 12, 32'h0, 1'b0);
    expect_rd("rst_x4", 1, 4, 32'h0, 1'b0);
    check_rd(); check_any("rst_post", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
